// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-count monitor.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 16;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_HOLD = 2'd0,
    CLS_UP   = 2'd1,
    CLS_DOWN = 2'd2,
    CLS_ERR  = 2'd3
  } step_cls_t;

  // Gray to binary: b[i] is the XOR of g[MSB:i]. Callers zero-extend narrower
  // codes, which leaves the decode of the low bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for an asynchronous gray-coded bus.
module gray_sync #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// Receives a gray-coded count, classifies each sampled transition and keeps
// a signed position total plus a saturating illegal-transition count.
module gray_count_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned POS_W       = 8,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_en,
  input  logic             clear,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             step_up,
  output logic             step_down,
  output logic             err_pulse,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [POS_W-1:0] pos
);

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] b_prev;
  logic [WIDTH-1:0] diff;
  step_cls_t        cls;
  state_t           state, state_nxt;
  logic             load, do_up, do_down, do_err;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gray_in),
    .q     (g_s)
  );

  assign b_s  = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
  assign diff = b_s - b_prev;

  // Classify the modular distance between the new sample and the reference.
  always_comb begin
    cls = CLS_ERR;
    if (diff == '0) begin
      cls = CLS_HOLD;
    end else if (diff == WIDTH'(1)) begin
      cls = CLS_UP;
    end else if (diff == '1) begin
      cls = CLS_DOWN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle actions; INIT only captures the reference.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_up     = 1'b0;
    do_down   = 1'b0;
    do_err    = 1'b0;
    if (clear) begin
      state_nxt = ST_INIT;
    end else if (sample_en) begin
      load      = 1'b1;
      state_nxt = ST_TRACK;
      if (state == ST_TRACK) begin
        do_up   = (cls == CLS_UP);
        do_down = (cls == CLS_DOWN);
        do_err  = (cls == CLS_ERR);
      end
    end
  end

  // Registered pulses, reference/output sample, position and error counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_prev    <= '0;
      bin_out   <= '0;
      valid     <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err_pulse <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
      pos       <= '0;
    end else begin
      step_up   <= do_up;
      step_down <= do_down;
      err_pulse <= do_err;
      if (clear) begin
        pos       <= '0;
        err_count <= '0;
        err_flag  <= 1'b0;
        valid     <= 1'b0;
      end else begin
        if (load) begin
          b_prev  <= b_s;
          bin_out <= b_s;
          valid   <= 1'b1;
        end
        if (do_up) begin
          pos <= pos + POS_W'(1);
        end
        if (do_down) begin
          pos <= pos - POS_W'(1);
        end
        if (do_err) begin
          err_flag <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_count_monitor.sv
// Self-checking bench for gray_count_monitor: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_gray_count_monitor;

  localparam int W  = 2;
  localparam int S  = 2;
  localparam int PW = 8;
  localparam int EW = 4;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic          clear;
  logic [W-1:0]  gray_in;
  logic [W-1:0]  bin_out;
  logic          valid, step_up, step_down, err_pulse, err_flag;
  logic [EW-1:0] err_count;
  logic [PW-1:0] pos;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_count_monitor #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .POS_W       (PW),
    .ERR_W       (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_in   (gray_in),
    .sample_en (sample_en),
    .clear     (clear),
    .bin_out   (bin_out),
    .valid     (valid),
    .step_up   (step_up),
    .step_down (step_down),
    .err_pulse (err_pulse),
    .err_flag  (err_flag),
    .err_count (err_count),
    .pos       (pos)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode by search: the binary value whose gray code matches.
  function automatic int gray_to_bin(input int g);
    for (int v = 0; v < MOD; v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  // Behavioural model: a queue delays gray_in by S samples, then the rules apply.
  int mq[$] = '{0, 0};
  bit m_valid = 0, m_up = 0, m_dn = 0, m_err = 0, m_flag = 0;
  int m_bin = 0, m_prev = 0, m_cnt = 0, m_pos = 0;

  always @(posedge clk or posedge reset) begin : model
    int gs, b, d;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < S; i++) mq.push_back(0);
      m_valid = 0; m_up = 0; m_dn = 0; m_err = 0; m_flag = 0;
      m_bin = 0; m_prev = 0; m_cnt = 0; m_pos = 0;
    end else begin
      m_up = 0; m_dn = 0; m_err = 0;
      gs = mq.pop_front();
      mq.push_back(int'(gray_in));
      if (clear) begin
        m_pos = 0; m_cnt = 0; m_flag = 0; m_valid = 0;
      end else if (sample_en) begin
        b = gray_to_bin(gs);
        if (m_valid) begin
          d = (b - m_prev + MOD) % MOD;
          if (d == 1) begin
            m_up = 1; m_pos = m_pos + 1;
          end else if (d == MOD - 1) begin
            m_dn = 1; m_pos = m_pos - 1;
          end else if (d != 0) begin
            m_err = 1; m_flag = 1;
            if (m_cnt < (1 << EW) - 1) m_cnt = m_cnt + 1;
          end
        end
        m_prev = b; m_bin = b; m_valid = 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus DUT pulse tallies.
  int c_up = 0, c_dn = 0, c_err = 0;
  always @(negedge clk) begin
    check("valid",     int'(valid),     int'(m_valid));
    check("bin_out",   int'(bin_out),   m_bin);
    check("step_up",   int'(step_up),   int'(m_up));
    check("step_down", int'(step_down), int'(m_dn));
    check("err_pulse", int'(err_pulse), int'(m_err));
    check("err_flag",  int'(err_flag),  int'(m_flag));
    check("err_count", int'(err_count), m_cnt);
    check("pos",       int'(pos),       m_pos & ((1 << PW) - 1));
    check("one_pulse", int'(step_up) + int'(step_down) + int'(err_pulse) <= 1 ? 1 : 0, 1);
    c_up  += int'(step_up);
    c_dn  += int'(step_down);
    c_err += int'(err_pulse);
  end

  task automatic hold_for(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new code and measure edges until any pulse appears (bounded).
  task automatic step_lat(input logic [W-1:0] g, input string name);
    int k;
    gray_in = g;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(step_up || step_down || err_pulse) && k < 8);
    check(name, k, S + 1);
    hold_for(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_up, s_dn, s_err;
    logic [W-1:0] br;
    logic [W-1:0] bin_seq [4];
    logic [W-1:0] up_seq [4];
    logic [W-1:0] dn_seq [4];
    up_seq  = '{2'b01, 2'b11, 2'b10, 2'b00};
    bin_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    dn_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};

    reset = 1'b1; sample_en = 1'b1; clear = 1'b0; gray_in = '0;
    #10;
    @(posedge clk); #1;
    check("reset_valid", int'(valid), 0);
    check("reset_pos", int'(pos), 0);
    reset = 1'b0;
    hold_for(4);
    check("ref_valid", int'(valid), 1);
    check("ref_bin", int'(bin_out), 0);

    // 1: four up-steps
    s_up = c_up; s_err = c_err;
    for (int i = 0; i < 4; i++) begin
      step_lat(up_seq[i], "lat_up");
      check("up_bin", int'(bin_out), int'(bin_seq[i]));
    end
    check("up_count", c_up - s_up, 4);
    check("up_pos", int'(pos), 4);
    check("model_pos_up", m_pos, 4);
    check("up_noerr", c_err - s_err, 0);

    // 2: four down-steps from a cleared position
    clear = 1'b1; hold_for(1); clear = 1'b0; hold_for(4);
    s_dn = c_dn;
    for (int i = 0; i < 4; i++) step_lat(dn_seq[i], "lat_dn");
    check("dn_count", c_dn - s_dn, 4);
    check("dn_pos", int'(pos), 8'hFC);
    check("dn_errcnt", int'(err_count), 0);

    // 3: illegal 2-step jump, then resynced legal step
    gray_in = 2'b11;
    hold_for(S + 1);
    check("jump_err", int'(err_pulse), 1);
    check("jump_flag", int'(err_flag), 1);
    check("jump_cnt", int'(err_count), 1);
    check("jump_pos", int'(pos), 8'hFC);
    check("jump_bin", int'(bin_out), 2);
    hold_for(1);
    step_lat(2'b10, "lat_resync");
    check("resync_bin", int'(bin_out), 3);
    check("resync_pos", int'(pos), 8'hFD);

    // 4: saturation of the error counter, then clear
    s_err = c_err;
    for (int i = 0; i < 20; i++) begin
      gray_in = (i % 2 == 0) ? 2'b01 : 2'b10;
      hold_for(4);
    end
    check("sat_pulses", c_err - s_err, 20);
    check("sat_cnt", int'(err_count), 15);
    check("sat_flag", int'(err_flag), 1);
    clear = 1'b1; hold_for(1);
    check("clr_cnt", int'(err_count), 0);
    check("clr_flag", int'(err_flag), 0);
    check("clr_pos", int'(pos), 0);
    check("clr_valid", int'(valid), 0);
    clear = 1'b0; hold_for(1);
    check("clr_revalid", int'(valid), 1);

    // 5: gaps with sample_en low
    gray_in = 2'b00; hold_for(4);
    sample_en = 1'b0;
    gray_in = 2'b01; hold_for(4);
    gray_in = 2'b11; hold_for(4);
    s_err = c_err; s_up = c_up;
    sample_en = 1'b1; hold_for(4);
    check("gap_err", c_err - s_err, 1);
    check("gap_noup", c_up - s_up, 0);
    check("gap_bin", int'(bin_out), 2);
    gray_in = 2'b10; hold_for(4);
    gray_in = 2'b00; hold_for(4);
    sample_en = 1'b0;
    gray_in = 2'b01; hold_for(4);
    s_up = c_up;
    sample_en = 1'b1; hold_for(4);
    check("gap_up_once", c_up - s_up, 1);

    // 6: asynchronous reset mid-count
    reset = 1'b1; hold_for(1); reset = 1'b0;
    gray_in = 2'b00; hold_for(4);
    gray_in = 2'b01; hold_for(4);
    gray_in = 2'b11; hold_for(4);
    gray_in = 2'b10; hold_for(4);
    check("pre_rst_pos", int'(pos), 3);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_pos", int'(pos), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_bin", int'(bin_out), 0);
    check("arst_flag", int'(err_flag), 0);
    gray_in = 2'b11; sample_en = 1'b0;
    hold_for(2);
    #2 reset = 1'b0;
    hold_for(S);
    s_up = c_up; s_dn = c_dn; s_err = c_err;
    sample_en = 1'b1; hold_for(1);
    check("rel_valid", int'(valid), 1);
    check("rel_bin", int'(bin_out), 2);
    hold_for(3);
    check("rel_nopulse", (c_up - s_up) + (c_dn - s_dn) + (c_err - s_err), 0);

    // Randomized walk: holds, legal steps, illegal jumps, gaps and clears
    br = 2'd2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: br = br + 2'd1;
        3, 4, 5: br = br - 2'd1;
        6:       br = br + 2'd2;
        default: br = br;
      endcase
      gray_in   = br ^ (br >> 1);
      sample_en = ($urandom_range(0, 4) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      hold_for(int'($urandom_range(1, 3)));
    end
    clear = 1'b0; sample_en = 1'b1;
    hold_for(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
